coin_sel_conditioner: RTL and testbench
=======================================

# coin_sel_conditioner

Input front end for the vending machine controller. It takes raw, bouncy, asynchronous coin-sensor and drink-button signals and turns them into clean single-cycle `M1`/`M2` coin pulses plus a held drink selection `sel`. These outputs drive the vending FSM directly. The block respects the FSM's `busy` indication so that no coin credit is lost or duplicated while a drink is being dispensed.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable cycles required before a debounced level changes; legal range 1..255.
- `QUEUE_DEPTH`, 4: coin-event FIFO depth; power of two. Used only with `COIN_QUEUE_EN`.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `coin1_raw` in 1: coin sensor, denomination 1; asynchronous, may bounce.
- `coin2_raw` in 1: coin sensor, denomination 2; asynchronous, may bounce.
- `btn_raw` in 3: drink buttons; asynchronous, may bounce.
- `busy` in 1: vending FSM is dispensing or returning change; new coin or selection events must not be issued.
- `M1` out 1: one-cycle pulse, one denomination-1 coin.
- `M2` out 1: one-cycle pulse, one denomination-2 coin.
- `sel` out 3: one-hot selection of the last accepted button press; held.
- `sel_valid` out 1: one-cycle pulse when `sel` is updated.
- `reject` out 1: one-cycle pulse when a coin event is discarded.

## Operation
- Each of the 5 raw inputs passes through a 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the counter reaches `DEB_CYCLES`, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level is an event. Falling edges generate nothing.
- Coin events:
  - When `busy`=0, the event issues the matching `M1` or `M2` pulse.
  - `M1` and `M2` are never high in the same cycle.
  - If coin1 and coin2 events occur in the same cycle, `M1` is issued first and `M2` the next cycle, via a 1-bit pending register.
- Button events:
  - Accepted only when `busy`=0.
  - If several buttons rise in the same cycle, the lowest index wins.
  - `sel` loads the one-hot value of the winning button and `sel_valid` pulses.
  - `sel` holds until the next accepted press.
  - Presses during `busy`=1 are dropped silently.
- Reset values: `M1`=0, `M2`=0, `sel`=3'b000, `sel_valid`=0, `reject`=0. Synchronizers, counters and debounced levels are all 0; the queue is empty; the pending register is clear.
- Reset mid-operation:
  - All in-flight events are discarded.
  - A raw input held high through reset produces exactly one event after release, after the full debounce latency.

## Timing
- Latency: raw input sampled high at edge t and held stable gives the output pulse high during the cycle following edge t+`DEB_CYCLES`+2.
- A bounce shorter than `DEB_CYCLES` cycles is never reported.
- All outputs are registered; none is combinational from `busy`.
- `busy` is sampled at the same edge that would issue the pulse. If `busy`=1 at that edge, the no-issue rule applies to that event.
- Output spacing: at most one coin pulse per cycle.

## Configuration
- Macro: `COIN_QUEUE_EN`.
- Defined:
  - Coin events arriving while `busy`=1, or while the queue is non-empty, are pushed in arrival order into a `QUEUE_DEPTH`-entry FIFO of coin type. When coin1 and coin2 arrive in the same cycle, coin1 is pushed first.
  - One entry pops per cycle while `busy`=0 and issues its pulse.
  - A push and a pop in the same cycle are both performed.
  - A push into a full queue is discarded and pulses `reject`; occupancy is unchanged.
  - Ordering is strict FIFO: a new event never overtakes queued entries.
- Undefined:
  - No FIFO is present.
  - Any coin event while `busy`=1 is discarded and pulses `reject`.
  - If both coins are discarded in the same cycle, `reject` pulses once per coin on consecutive cycles.

## Structure
- Package `vending_pkg` holds:
  - `coin_t` enum (`COIN_1`, `COIN_2`).
  - `SEL_W`=3.
  - `DEB_CYCLES_DEFAULT`=4.
  - The queue-pointer width function.
- Sub-module `debouncer`: synchronizer, counter and rising-edge detector with 1-bit output `rise`. It is instantiated 5 times in the top level.
- Coin arbitration and the queue/pending logic live in the top level.

## Test plan
- `coin1_raw` high from edge 0, `busy`=0, `DEB_CYCLES`=4 → single `M1` pulse in cycle 6 (cycle following edge 6); no `M2`; `reject`=0.
- `coin2_raw` toggles every 2 cycles for 10 cycles, then holds high → no pulse during the toggling; exactly one `M2` pulse 6 cycles after the final rise.
- Both coins rise on the same edge, `busy`=0 → `M1` in cycle N, `M2` in cycle N+1.
- `btn_raw`=3'b110 rises together, `busy`=0 → `sel`=3'b010, one `sel_valid` pulse. A later `btn_raw`=3'b100 press while `busy`=1 → `sel` stays 3'b010, no pulse.
- With `COIN_QUEUE_EN`, `busy`=1: five coin1 events, then `busy`→0 → `reject` once (on the 5th event), then four `M1` pulses on consecutive cycles. Without the macro → five `reject` pulses and no `M1`.
- `reset` asserted for 1 cycle with `coin1_raw` held high mid-debounce → all outputs 0 after reset; exactly one `M1` pulse 6 cycles after the first post-reset edge.

Source files
------------

// File: rtl/coin_sel_conditioner_pkg.sv
// Shared types and constants for the vending machine input front end.
// Also provides the queue-pointer width helper used when COIN_QUEUE_EN is defined.
package vending_pkg;

    typedef enum logic {
        COIN_1 = 1'b0,
        COIN_2 = 1'b1
    } coin_t;

    localparam int SEL_W              = 3;
    localparam int DEB_CYCLES_DEFAULT = 4;

    // A depth of one still needs a one-bit pointer so the storage index is never zero-width.
    function automatic int queuePtrW(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/coin_sel_conditioner_debouncer.sv
// One raw input channel: 2-flop synchronizer, stability counter and debounced level.
// Produces a one-cycle 'rise' pulse when the debounced level goes from 0 to 1.
module debouncer
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] DEB_LIM = 8'(DEB_CYCLES);

    logic [1:0] sync_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rise_q, rise_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= 8'd0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    // Any cycle where the synchronized value agrees with the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = 8'd0;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q + 8'd1 == DEB_LIM) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/coin_sel_conditioner.sv
// Debounces coin sensors and drink buttons into clean M1/M2 pulses and a held selection.
// Optional macro COIN_QUEUE_EN adds a coin FIFO that holds coins arriving while busy.
module coin_sel_conditioner
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin1_raw,
    input  logic             coin2_raw,
    input  logic [SEL_W-1:0] btn_raw,
    input  logic             busy,
    output logic             M1,
    output logic             M2,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             reject
);

    if (QUEUE_DEPTH < 1 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_badDepth
        $error("QUEUE_DEPTH must be a power of two");
    end

    logic             coin1Rise, coin2Rise;
    logic [SEL_W-1:0] btnRise;

    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_coin1 (.clk(clk), .reset(reset), .raw(coin1_raw), .rise(coin1Rise));
    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_coin2 (.clk(clk), .reset(reset), .raw(coin2_raw), .rise(coin2Rise));

    for (genvar b = 0; b < SEL_W; b++) begin : g_btn
        debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_btn (.clk(clk), .reset(reset), .raw(btn_raw[b]), .rise(btnRise[b]));
    end

    logic             pend_q, pend_d;
    logic             arrValid;
    coin_t            arrCoin;
    logic             issueValid;
    coin_t            issueCoin;
    logic             M1_q, M2_q, reject_q, reject_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             selValid_q, selValid_d;

`ifdef COIN_QUEUE_EN
    localparam int PTR_W = queuePtrW(QUEUE_DEPTH);

    coin_t            fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             pushEn, popEn, qEmpty, qFull;

    assign qEmpty = (count_q == '0);
    assign qFull  = (count_q == (PTR_W + 1)'(QUEUE_DEPTH));

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) wrPtr_q <= nextPtr(wrPtr_q);
            if (popEn)  rdPtr_q <= nextPtr(rdPtr_q);
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) fifo_q[wrPtr_q] <= arrCoin;
    end
`endif

    // Coins are serialized to one arrival per cycle; a simultaneous coin2 waits one cycle in pend_q.
    always_comb begin
        pend_d     = coin1Rise & coin2Rise;
        arrValid   = pend_q | coin1Rise | coin2Rise;
        arrCoin    = (pend_q || !coin1Rise) ? COIN_2 : COIN_1;
        issueValid = 1'b0;
        issueCoin  = COIN_1;
        reject_d   = 1'b0;
`ifdef COIN_QUEUE_EN
        pushEn = 1'b0;
        popEn  = 1'b0;
        if (!busy && !qEmpty) begin
            popEn      = 1'b1;
            issueValid = 1'b1;
            issueCoin  = fifo_q[rdPtr_q];
        end
        if (arrValid) begin
            if (!busy && qEmpty) begin
                issueValid = 1'b1;
                issueCoin  = arrCoin;
            end else if (qFull && !popEn) begin
                reject_d = 1'b1;
            end else begin
                pushEn = 1'b1;
            end
        end
`else
        if (arrValid) begin
            if (busy) begin
                reject_d = 1'b1;
            end else begin
                issueValid = 1'b1;
                issueCoin  = arrCoin;
            end
        end
`endif
    end

    // Lowest-index button wins when several rise together.
    always_comb begin
        selValid_d = !busy && (|btnRise);
        sel_d      = selValid_d ? (btnRise & (~btnRise + SEL_W'(1))) : sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            M1_q       <= 1'b0;
            M2_q       <= 1'b0;
            reject_q   <= 1'b0;
            sel_q      <= '0;
            selValid_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            M1_q       <= issueValid && (issueCoin == COIN_1);
            M2_q       <= issueValid && (issueCoin == COIN_2);
            reject_q   <= reject_d;
            sel_q      <= sel_d;
            selValid_q <= selValid_d;
        end
    end

    assign M1        = M1_q;
    assign M2        = M2_q;
    assign reject    = reject_q;
    assign sel       = sel_q;
    assign sel_valid = selValid_q;

endmodule

// File: tb/tb_coin_sel_conditioner.sv
// Directed bench for coin_sel_conditioner with default DEB_CYCLES=4, QUEUE_DEPTH=4.
// Expected pulse cycles are hand-computed; cycle index 0 is the first edge after stimulus changes.
module tb_coin_sel_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin1_raw, coin2_raw, busy;
    logic [2:0] btn_raw;
    logic       M1, M2, sel_valid, reject;
    logic [2:0] sel;

    int errors = 0;
    int checks = 0;
    int m1Count, m1First, m1Last, m2Count, m2First, rejCount, svCount, overlap;

    coin_sel_conditioner dut (
        .clk(clk), .reset(reset), .coin1_raw(coin1_raw), .coin2_raw(coin2_raw),
        .btn_raw(btn_raw), .busy(busy), .M1(M1), .M2(M2), .sel(sel),
        .sel_valid(sel_valid), .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearStats();
        m1Count = 0; m1First = -1; m1Last = -1;
        m2Count = 0; m2First = -1;
        rejCount = 0; svCount = 0; overlap = 0;
    endtask

    // One active edge, then sample on the following falling edge.
    task automatic applyStimulus(input int idx);
        @(posedge clk);
        @(negedge clk);
        if (M1) begin
            if (m1Count == 0) m1First = idx;
            m1Last = idx;
            m1Count++;
        end
        if (M2) begin
            if (m2Count == 0) m2First = idx;
            m2Count++;
        end
        if (M1 && M2) overlap++;
        if (reject) rejCount++;
        if (sel_valid) svCount++;
    endtask

    task automatic idle(input int n);
        clearStats();
        for (int i = 0; i < n; i++) applyStimulus(i);
    endtask

    initial begin
        reset = 1'b1; coin1_raw = 1'b0; coin2_raw = 1'b0; btn_raw = 3'b000; busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_M1", M1, 0);
        checkOutput("reset_M2", M2, 0);
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_sel_valid", sel_valid, 0);
        checkOutput("reset_reject", reject, 0);
        reset = 1'b0;
        idle(4);

        $display("[TB] single coin1");
        coin1_raw = 1'b1;
        idle(14);
        checkOutput("c1_first", m1First, 6);
        checkOutput("c1_count", m1Count, 1);
        checkOutput("c1_no_m2", m2Count, 0);
        checkOutput("c1_no_reject", rejCount, 0);
        coin1_raw = 1'b0;
        idle(10);
        checkOutput("c1_fall_silent", m1Count, 0);

        $display("[TB] bouncing coin2");
        clearStats();
        for (int i = 0; i < 24; i++) begin
            coin2_raw = (i >= 10) ? 1'b1 : (((i / 2) % 2) == 0);
            applyStimulus(i);
        end
        checkOutput("c2_first", m2First, 14);
        checkOutput("c2_count", m2Count, 1);
        checkOutput("c2_no_m1", m1Count, 0);
        coin2_raw = 1'b0;
        idle(10);

        $display("[TB] simultaneous coins");
        coin1_raw = 1'b1; coin2_raw = 1'b1;
        idle(14);
        checkOutput("both_m1_first", m1First, 6);
        checkOutput("both_m2_first", m2First, 7);
        checkOutput("both_m1_count", m1Count, 1);
        checkOutput("both_m2_count", m2Count, 1);
        checkOutput("both_overlap", overlap, 0);
        coin1_raw = 1'b0; coin2_raw = 1'b0;
        idle(10);

        $display("[TB] buttons");
        btn_raw = 3'b110;
        idle(12);
        checkOutput("btn_sel", sel, 3'b010);
        checkOutput("btn_sv_count", svCount, 1);
        btn_raw = 3'b000;
        idle(10);
        busy = 1'b1;
        btn_raw = 3'b100;
        idle(12);
        checkOutput("btn_busy_sel", sel, 3'b010);
        checkOutput("btn_busy_sv", svCount, 0);
        btn_raw = 3'b000;
        idle(10);

        $display("[TB] coins while busy");
        clearStats();
        for (int i = 0; i < 70; i++) begin
            coin1_raw = (i < 60) && ((i % 12) < 6);
            applyStimulus(i);
        end
`ifdef COIN_QUEUE_EN
        checkOutput("busy_reject", rejCount, 1);
`else
        checkOutput("busy_reject", rejCount, 5);
`endif
        checkOutput("busy_no_m1", m1Count, 0);
        busy = 1'b0;
        idle(10);
`ifdef COIN_QUEUE_EN
        checkOutput("drain_count", m1Count, 4);
        checkOutput("drain_first", m1First, 0);
        checkOutput("drain_last", m1Last, 3);
`else
        checkOutput("drain_count", m1Count, 0);
`endif
        checkOutput("drain_no_reject", rejCount, 0);

        $display("[TB] reset mid-debounce");
        coin1_raw = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(1);
        checkOutput("rst_M1", M1, 0);
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_reject", reject, 0);
        reset = 1'b0;
        idle(14);
        checkOutput("rst_m1_first", m1First, 6);
        checkOutput("rst_m1_count", m1Count, 1);
        checkOutput("rst_sel_after", sel, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
